// File: rtl/mldsa_params_pkg.sv
// mldsa_params_pkg: shared memory-port types and widths for the ML-DSA datapath.
package mldsa_params_pkg;
    localparam int MEM_DATA_WIDTH       = 32;
    localparam int MLDSA_MEM_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'd0,
        RW_READ  = 2'd1,
        RW_WRITE = 2'd2
    } mem_rw_mode_e;

    typedef struct packed {
        mem_rw_mode_e                    rw_mode;
        logic [MLDSA_MEM_ADDR_WIDTH-1:0] addr;
    } mem_if_t;

    localparam mem_if_t MEM_IF_IDLE = '{rw_mode: RW_IDLE, addr: '0};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        FLUSH,
        DONE
    } ntt_mem_xfer_state_e;
endpackage

// File: rtl/ntt_mem_xfer_fifo.sv
// ntt_mem_xfer_fifo: show-ahead synchronous FIFO buffering drained memory words.
module ntt_mem_xfer_fifo
    import mldsa_params_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_clr,
    input  logic                      i_push,
    input  logic [MEM_DATA_WIDTH-1:0] i_data,
    input  logic                      i_pop,
    output logic [MEM_DATA_WIDTH-1:0] o_data,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [MEM_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [AW:0]               r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/ntt_mem_xfer.sv
// ntt_mem_xfer: bulk load (stream -> port 0 writes) and drain (port 1 reads -> stream)
// engine for the NTT/PWM coefficient memories.
module ntt_mem_xfer
    import mldsa_params_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            zeroize,
    input  logic                            load_start,
    input  logic                            drain_start,
    input  logic [MLDSA_MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [MLDSA_MEM_ADDR_WIDTH:0]   num_words,
    output logic                            busy,
    output logic                            done,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MEM_DATA_WIDTH-1:0]       in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MEM_DATA_WIDTH-1:0]       out_data,
    output mem_if_t                         mem_port0_req,
    output logic [MEM_DATA_WIDTH-1:0]       p0_write_data,
    output mem_if_t                         mem_port1_req,
    input  logic [MEM_DATA_WIDTH-1:0]       p1_read_data
);
    localparam int AW = MLDSA_MEM_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ntt_mem_xfer_state_e       r_state, w_next;
    logic [AW-1:0]             r_addr, w_cur_addr;
    logic [AW:0]               r_rem, w_cur_rem;
    mem_if_t                   r_p0, r_p1;
    logic [MEM_DATA_WIDTH-1:0] r_p0_data, w_fifo_data;
    logic                      r_rd_vld;
    logic                      w_idle, w_start_ld, w_start_dr, w_wr, w_rd, w_pop, w_flushed;
    logic [1:0]                w_inflight;
    logic [CW-1:0]             w_count;
    logic [CW:0]               w_used;

    // A drain's first read is issued from IDLE so the registered request lands in cycle 1.
    assign w_idle     = r_state == IDLE;
    assign w_start_ld = w_idle & load_start;
    assign w_start_dr = w_idle & drain_start & ~load_start;
    assign w_cur_addr = w_idle ? base_addr : r_addr;
    assign w_cur_rem  = w_idle ? num_words : r_rem;
    assign w_inflight = 2'(r_p1.rw_mode == RW_READ) + 2'(r_rd_vld);
    assign w_used     = (CW+1)'(w_count) + (CW+1)'(w_inflight);
    assign out_valid  = w_count != '0;
    assign w_pop      = out_valid & out_ready;
    assign in_ready   = (r_state == LOAD) && (r_rem != '0);
    assign w_wr       = in_ready & in_valid;
    assign w_rd       = (w_start_dr || r_state == DRAIN) && (w_cur_rem != '0)
                        && (w_used < (CW+1)'(FIFO_DEPTH) + (CW+1)'(w_pop));
    assign w_flushed  = (w_inflight == 2'd0) && (w_count == CW'(w_pop));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_start_ld || w_start_dr) ? ((num_words == '0) ? DONE : (w_start_ld ? LOAD : DRAIN)) : IDLE;
            LOAD:    w_next = (r_rem == '0) ? DONE : LOAD;
            DRAIN:   w_next = (r_rem == '0) ? FLUSH : DRAIN;
            FLUSH:   w_next = w_flushed ? DONE : FLUSH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_p0      <= MEM_IF_IDLE;
            r_p0_data <= '0;
            r_p1      <= MEM_IF_IDLE;
            r_rd_vld  <= 1'b0;
        end else if (zeroize) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_p0      <= MEM_IF_IDLE;
            r_p0_data <= '0;
            r_p1      <= MEM_IF_IDLE;
            r_rd_vld  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ld || w_start_dr || w_wr || w_rd) begin
                r_addr <= w_cur_addr + AW'(w_wr | w_rd);
                r_rem  <= w_cur_rem - (AW+1)'(w_wr | w_rd);
            end
            r_p0      <= w_wr ? mem_if_t'{rw_mode: RW_WRITE, addr: r_addr} : MEM_IF_IDLE;
            r_p0_data <= w_wr ? in_data : '0;
            r_p1      <= w_rd ? mem_if_t'{rw_mode: RW_READ, addr: w_cur_addr} : MEM_IF_IDLE;
            r_rd_vld  <= r_p1.rw_mode == RW_READ;
        end
    end

    ntt_mem_xfer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (zeroize),
        .i_push  (r_rd_vld),
        .i_data  (p1_read_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_count)
    );

    assign busy          = !w_idle;
    assign done          = r_state == DONE;
    assign out_data      = out_valid ? w_fifo_data : '0;
    assign mem_port0_req = r_p0;
    assign p0_write_data = r_p0_data;
    assign mem_port1_req = r_p1;
endmodule

// File: tb/tb_ntt_mem_xfer.sv
// tb_ntt_mem_xfer: directed load/drain scenarios against a behavioural memory,
// with cycle-accurate expectations relative to the start pulse.
module tb_ntt_mem_xfer;
    import mldsa_params_pkg::*;

    typedef struct {
        int          c;
        int          a;
        logic [31:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n, zeroize, load_start, drain_start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic        busy, done, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data, p0_write_data, p1_read_data;
    mem_if_t     mem_port0_req, mem_port1_req;

    logic [31:0] mem [256];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;

    ev_t         wr_q[$], rd_q[$], out_q[$];
    int          cyc, t0, wm, rm, om, dm, done_n, done_c, hold_bad;
    int          n_chk, n_err;
    logic        hold_pv;
    logic [31:0] hold_pd;
    logic [7:0]  zz_snap;
    logic [31:0] words [16];
    bit          got;

    always #5 clk = ~clk;

    ntt_mem_xfer #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .zeroize       (zeroize),
        .load_start    (load_start),
        .drain_start   (drain_start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .mem_port0_req (mem_port0_req),
        .p0_write_data (p0_write_data),
        .mem_port1_req (mem_port1_req),
        .p1_read_data  (p1_read_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: one-cycle read latency on port 1, writes on port 0, plus a backdoor.
    always @(posedge clk) begin
        p1_read_data <= (mem_port1_req.rw_mode == RW_READ) ? mem[mem_port1_req.addr] : '0;
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_port0_req.rw_mode == RW_WRITE) mem[mem_port0_req.addr] <= p0_write_data;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_port0_req.rw_mode != RW_IDLE) wr_q.push_back('{cyc, int'(mem_port0_req.addr), p0_write_data});
            if (mem_port1_req.rw_mode != RW_IDLE) rd_q.push_back('{cyc, int'(mem_port1_req.addr), 32'(mem_port1_req.rw_mode)});
            if (out_valid && out_ready) out_q.push_back('{cyc, 0, out_data});
            if (done) begin
                done_n++;
                done_c = cyc;
            end
            if (hold_pv && (!out_valid || out_data !== hold_pd)) hold_bad++;
            hold_pv = out_valid && !out_ready;
            hold_pd = out_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Runs one transfer; cycle 0 is the cycle carrying the start pulse.
    task automatic xfer(input bit is_load, input logic [7:0] base, input int n, input int dr_at,
                        input int bp_from, input int bp_len, input int zz_at, output bit got_done);
        int idx;
        int rel;
        bit hs;
        idx = 0;
        got_done = 0;
        wm = wr_q.size(); rm = rd_q.size(); om = out_q.size(); dm = done_n;
        @(posedge clk); #1;
        t0 = cyc;
        base_addr = base; num_words = 9'(n);
        load_start = is_load; drain_start = !is_load || dr_at == 0; zeroize = zz_at == 0;
        in_valid = is_load && n > 0; in_data = words[0]; out_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            hs = in_valid && in_ready;
            if (rel == zz_at + 1)
                zz_snap = {busy, done, out_valid, in_ready, mem_port0_req.rw_mode, mem_port1_req.rw_mode};
            if (done) begin
                got_done = 1;
                break;
            end
            if (zz_at >= 0 && rel >= zz_at + 10) break;
            @(posedge clk); #1;
            rel = cyc - t0;
            load_start = 0; drain_start = rel == dr_at; zeroize = rel == zz_at;
            if (hs) idx++;
            in_valid = is_load && idx < n; in_data = words[idx];
            out_ready = !(rel >= bp_from && rel < bp_from + bp_len);
        end
        @(posedge clk); #1;
        load_start = 0; drain_start = 0; zeroize = 0; in_valid = 0; out_ready = 1;
    endtask

    initial begin
        int stall_rd;
        reset_n = 0; zeroize = 0; load_start = 0; drain_start = 0; base_addr = 0; num_words = 0;
        in_valid = 0; in_data = 0; out_ready = 1; bd_we = 0; bd_addr = 0; bd_data = 0;
        hold_pv = 0; hold_pd = 0; zz_snap = '1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_p0", mem_port0_req, 0);
        check("rst_p0_data", p0_write_data, 0);
        check("rst_p1", mem_port1_req, 0);
        @(negedge clk) reset_n = 1;

        for (int i = 0; i < 4; i++) words[i] = 32'hA + 32'(i);
        xfer(1, 8'h10, 4, -1, -1, 0, -1, got);
        check("ld_done", got, 1);
        check("ld_done_cyc", done_c - t0, 6);
        check("ld_nwr", wr_q.size() - wm, 4);
        check("ld_nrd", rd_q.size() - rm, 0);
        for (int i = 0; i < 4; i++) begin
            check("ld_wr_cyc", wr_q[wm+i].c - t0, 2 + i);
            check("ld_wr_addr", wr_q[wm+i].a, 'h10 + i);
            check("ld_wr_data", wr_q[wm+i].d, 'hA + i);
            check("ld_mem", mem[8'h10 + 8'(i)], 'hA + i);
        end

        xfer(0, 8'h10, 4, -1, -1, 0, -1, got);
        check("dr_done", got, 1);
        check("dr_done_cyc", done_c - t0, 7);
        check("dr_nrd", rd_q.size() - rm, 4);
        check("dr_nout", out_q.size() - om, 4);
        check("dr_nwr", wr_q.size() - wm, 0);
        for (int i = 0; i < 4; i++) begin
            check("dr_rd_cyc", rd_q[rm+i].c - t0, 1 + i);
            check("dr_rd_addr", rd_q[rm+i].a, 'h10 + i);
            check("dr_rd_mode", rd_q[rm+i].d, 32'(RW_READ));
            check("dr_out_cyc", out_q[om+i].c - t0, 3 + i);
            check("dr_out_data", out_q[om+i].d, 'hA + i);
        end

        for (int i = 0; i < 8; i++) bd_write(8'h20 + 8'(i), 32'h100 + 32'(i));
        xfer(0, 8'h20, 8, -1, 2, 10, -1, got);
        stall_rd = 0;
        for (int i = rm; i < rd_q.size(); i++) if (rd_q[i].c - t0 <= 12) stall_rd++;
        check("bp_done", got, 1);
        check("bp_stall_reads", stall_rd, 4);
        check("bp_nrd", rd_q.size() - rm, 8);
        check("bp_nout", out_q.size() - om, 8);
        for (int i = 0; i < 8; i++) begin
            check("bp_rd_addr", rd_q[rm+i].a, 'h20 + i);
            check("bp_out_data", out_q[om+i].d, 'h100 + i);
        end
        check("bp_hold_stable", hold_bad, 0);

        for (int i = 0; i < 4; i++) words[i] = 32'h50 + 32'(i);
        xfer(1, 8'hFE, 4, -1, -1, 0, -1, got);
        check("wrap_done", got, 1);
        check("wrap_nwr", wr_q.size() - wm, 4);
        check("wrap_addr0", wr_q[wm].a, 'hFE);
        check("wrap_addr1", wr_q[wm+1].a, 'hFF);
        check("wrap_addr2", wr_q[wm+2].a, 'h00);
        check("wrap_addr3", wr_q[wm+3].a, 'h01);
        check("wrap_mem", mem[8'h00], 'h52);

        xfer(1, 8'h30, 0, -1, -1, 0, -1, got);
        check("n0_ld_done", got, 1);
        check("n0_ld_cyc", done_c - t0, 1);
        check("n0_ld_access", (wr_q.size() - wm) + (rd_q.size() - rm), 0);
        xfer(0, 8'h30, 0, -1, -1, 0, -1, got);
        check("n0_dr_cyc", done_c - t0, 1);
        check("n0_dr_access", (wr_q.size() - wm) + (rd_q.size() - rm) + (out_q.size() - om), 0);

        words[0] = 32'h60; words[1] = 32'h61;
        xfer(1, 8'h40, 2, 0, -1, 0, -1, got);
        check("both_done_cyc", done_c - t0, 4);
        check("both_nwr", wr_q.size() - wm, 2);
        check("both_nrd", rd_q.size() - rm, 0);
        check("both_mem", mem[8'h41], 'h61);

        for (int i = 0; i < 4; i++) words[i] = 32'h70 + 32'(i);
        xfer(1, 8'h44, 4, 2, -1, 0, -1, got);
        check("drmid_done_cyc", done_c - t0, 6);
        check("drmid_nwr", wr_q.size() - wm, 4);
        check("drmid_nrd", rd_q.size() - rm, 0);

        xfer(0, 8'h20, 8, -1, -1, 0, 5, got);
        check("zz_no_done", done_n - dm, 0);
        check("zz_snapshot", zz_snap, 0);
        xfer(0, 8'h20, 4, -1, -1, 0, -1, got);
        check("zz_after_done_cyc", done_c - t0, 7);
        check("zz_after_nout", out_q.size() - om, 4);
        for (int i = 0; i < 4; i++) begin
            check("zz_after_cyc", out_q[om+i].c - t0, 3 + i);
            check("zz_after_data", out_q[om+i].d, 'h100 + i);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ntt_mem_xfer.md
# ntt_mem_xfer

Front-door bulk transfer engine for the NTT/PWM coefficient memories. It loads a stream of memory words into a memory through the write port (port 0) and drains a contiguous region back out as a stream through the read port (port 1), issuing `mem_if_t` requests as a real master would. It sits between a streaming source/sink (sampler, keccak unpack, test harness) and `ntt_mem`, `pwm_mem_a` or `pwm_mem_b`.

## Interface
- `FIFO_DEPTH`, 4: drain-side output buffer depth in words; a power of two, ≥4, required for 1 word/cycle drain.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous reset, active low.
- `zeroize` in 1: synchronous clear, same effect as reset.
- `load_start` in 1: one-cycle pulse; begins a load, sampled only in IDLE.
- `drain_start` in 1: one-cycle pulse; begins a drain, sampled only in IDLE.
- `base_addr` in `MLDSA_MEM_ADDR_WIDTH`: first word address, captured on start.
- `num_words` in `MLDSA_MEM_ADDR_WIDTH+1`: word count, captured on start.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `in_valid` in 1, `in_ready` out 1, `in_data` in `MEM_DATA_WIDTH`: load stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `MEM_DATA_WIDTH`: drain stream.
- `mem_port0_req` out `mem_if_t`, `p0_write_data` out `MEM_DATA_WIDTH`: write port.
- `mem_port1_req` out `mem_if_t`, `p1_read_data` in `MEM_DATA_WIDTH`: read port; data is valid the cycle after an RW_READ request.

## Operation
- Reset or zeroize: state IDLE; all outputs 0; both port requests RW_IDLE with addr 0; FIFO empty; counters cleared.
- States:
  - IDLE: `load_start` moves to LOAD, `drain_start` to DRAIN. If both pulse together, LOAD wins and `drain_start` is dropped.
  - LOAD: `in_ready` is high while words remain. Each `in_valid & in_ready` handshake registers an RW_WRITE at the current address with `p0_write_data=in_data`. After the last handshake the state moves to DONE.
  - DRAIN: issues an RW_READ per cycle while words remain and `fifo_count + inflight < FIFO_DEPTH`. The credit check counts a same-cycle pop as freed. Returned data is pushed into the FIFO one cycle after its request. After the last read is issued the state moves to FLUSH.
  - FLUSH: waits until inflight is 0 and the FIFO is empty (last word popped), then moves to DONE.
  - DONE: `done` is high for one cycle, then the state returns to IDLE.
- Address increments by 1 per word and wraps modulo 2^`MLDSA_MEM_ADDR_WIDTH`.
- `num_words=0`: the state goes directly to DONE with no memory access.
- Starts are ignored outside IDLE.
- Zeroize mid-transfer: immediate return to IDLE; no `done`; read data still in flight is discarded.
- `busy` is high in every state except IDLE.
- Port requests are RW_IDLE whenever no access is issued. Port 0 never reads; port 1 never writes.

## Timing
- All port requests come from registers.
- Load, `load_start` in cycle 0:
  - `in_ready` first high in cycle 1.
  - A handshake in cycle k puts its write on port 0 in cycle k+1.
  - With `in_valid` held high for N words: writes in cycles 2..N+1, `done` in cycle N+2.
- Drain, `drain_start` in cycle 0, `out_ready` held high:
  - Reads in cycles 1..N.
  - `p1_read_data` sampled in cycles 2..N+1.
  - `out_valid` in cycles 3..N+2.
  - `done` in cycle N+3.
- `out_valid`/`out_data` are held stable until `out_ready`. Data is never lost under any backpressure pattern.
- At most `FIFO_DEPTH` words are outstanding (buffered plus in flight).

## Structure
- `mldsa_params_pkg` already provides `mem_if_t`, `mem_rw_mode_e`, `MEM_DATA_WIDTH` and `MLDSA_MEM_ADDR_WIDTH`.
- Add `ntt_mem_xfer_state_e` (IDLE, LOAD, DRAIN, FLUSH, DONE) to `mldsa_params_pkg`.
- Sub-module `ntt_mem_xfer_fifo`: synchronous FIFO of depth `FIFO_DEPTH` and width `MEM_DATA_WIDTH`, with count output, clear input, and show-ahead read.

## Test plan
- Load: base 0x10, N=4, words 0xA..0xD streamed back-to-back. Port 0 writes 0x10–0x13 in cycles 2–5; `done` in cycle 6; backdoor memory read matches.
- Drain, no backpressure: memory preloaded with 0x10–0x13 = 0xA..0xD. `out_data` shows 0xA..0xD in cycles 3–6; `done` in cycle 7.
- Drain with backpressure: `out_ready` low for 10 cycles from cycle 2, N=8. Exactly 4 reads are issued and then stall; all 8 words arrive in order; no duplicates.
- Wrap-around: base 2^W−2, N=4. Addresses go 2^W−2, 2^W−1, 0, 1.
- Corner cases:
  - `num_words=0`: `done` one cycle after entering DONE, no port activity.
  - `load_start` and `drain_start` in the same cycle: a load runs.
  - `drain_start` during a load: ignored.
- `zeroize` in the middle of an N=8 drain: next cycle is IDLE, ports RW_IDLE, `out_valid`=0, no `done`. A following drain produces correct data.
